// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings and the operand bundle
// used by the ALU, the arbiter that shares it, and the decoder.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU: wrap-around add/sub, logic ops, signed
// set-less-than and shifts by b[4:0], plus a zero flag on the result.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter: a lone request always wins; on a conflict either requester 0
// wins (fixed_prio) or the requester that did not win last time.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       fixed_prio,
  input  logic       enable,
  output logic       grant_valid,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (&valid) begin
      grant = fixed_prio ? 1'b0 : ~last_grant;
    end else begin
      grant = valid[1];
    end
    grant_valid = enable & (|valid);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters; each result is
// held in a single registered slot until its owner consumes it.
module alu_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero
);

  logic                      slot_valid;
  logic                      slot_owner;
  logic [DATA_W-1:0]         slot_result;
  logic                      slot_zero;
  logic                      last_grant;

  logic                      drain;
  logic                      can_accept;
  logic                      grant_valid;
  logic                      grant;
  alu_pkg::alu_req_t         sel;
  logic [alu_pkg::DATA_W-1:0] alu_result;
  logic                      alu_zero;

  assign drain      = slot_valid & (slot_owner ? resp1_ready : resp0_ready);
  assign can_accept = ~slot_valid | drain;

  rr_arb2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .fixed_prio  (FIXED_PRIO != 0),
    .enable      (can_accept & ~rst),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Requester 0 drives the ALU whenever requester 1 is not actually granted.
  always_comb begin
    if (grant_valid & grant) begin
      sel.a  = req1_a;
      sel.b  = req1_b;
      sel.op = req1_op;
    end else begin
      sel.a  = req0_a;
      sel.b  = req0_b;
      sel.op = req0_op;
    end
  end

  alu u_alu (
    .a      (sel.a),
    .b      (sel.b),
    .op     (sel.op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign req0_ready = grant_valid & ~grant;
  assign req1_ready = grant_valid & grant;

  assign resp0_valid  = ~rst & slot_valid & ~slot_owner;
  assign resp1_valid  = ~rst & slot_valid & slot_owner;
  assign resp0_result = slot_result;
  assign resp1_result = slot_result;
  assign resp0_zero   = slot_zero;
  assign resp1_zero   = slot_zero;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result payload is reset too; it is observable on the response ports.
      slot_valid  <= 1'b0;
      slot_owner  <= 1'b0;
      slot_result <= '0;
      slot_zero   <= 1'b0;
      last_grant  <= 1'b1;
    end else if (grant_valid) begin
      slot_valid  <= 1'b1;
      slot_owner  <= grant;
      slot_result <= alu_result;
      slot_zero   <= alu_zero;
      last_grant  <= grant;
    end else if (drain) begin
      slot_valid  <= 1'b0;
    end
  end

  // Requesters must hold a pending operation unchanged until it is accepted.
  req0_hold_a : assert property (@(posedge clk) disable iff (rst)
    (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_a) && $stable(req0_b) && $stable(req0_op)))
    else $error("req0 changed or dropped a pending operation");

  req1_hold_a : assert property (@(posedge clk) disable iff (rst)
    (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_a) && $stable(req1_b) && $stable(req1_op)))
    else $error("req1 changed or dropped a pending operation");

endmodule

// File: tb/tb_alu_arbiter.sv
// Two arbiters (round-robin and fixed priority) driven by queued requesters; a
// transaction-level model predicts grants and results, a monitor checks responses.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } op_t;

  typedef struct {
    logic [31:0] result;
    logic        zero;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rq_valid  [2][2];
  logic [31:0] rq_a      [2][2];
  logic [31:0] rq_b      [2][2];
  logic [2:0]  rq_op     [2][2];
  logic        rs_ready  [2][2];
  wire         rq_ready  [2][2];
  wire         rs_valid  [2][2];
  wire  [31:0] rs_result [2][2];
  wire         rs_zero   [2][2];

  int checks   = 0;
  int failures = 0;

  op_t  opq   [2][2][$];
  rsp_t exp_q [2][2][$];
  int   outst [2][$];
  logic last  [2];
  logic hs    [2][2];
  logic ph_rst;
  logic ph_rsr [2][2];

  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_arbiter #(.DATA_W(32), .FIXED_PRIO(g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (rq_valid[g][0]),
      .req0_ready   (rq_ready[g][0]),
      .req0_a       (rq_a[g][0]),
      .req0_b       (rq_b[g][0]),
      .req0_op      (rq_op[g][0]),
      .req1_valid   (rq_valid[g][1]),
      .req1_ready   (rq_ready[g][1]),
      .req1_a       (rq_a[g][1]),
      .req1_b       (rq_b[g][1]),
      .req1_op      (rq_op[g][1]),
      .resp0_valid  (rs_valid[g][0]),
      .resp0_ready  (rs_ready[g][0]),
      .resp0_result (rs_result[g][0]),
      .resp0_zero   (rs_zero[g][0]),
      .resp1_valid  (rs_valid[g][1]),
      .resp1_ready  (rs_ready[g][1]),
      .resp1_result (rs_result[g][1]),
      .resp1_zero   (rs_zero[g][1])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic rsp_t alu_ref(input op_t o);
    rsp_t r;
    case (o.op)
      ALU_ADD: r.result = o.a + o.b;
      ALU_SUB: r.result = o.a - o.b;
      ALU_AND: r.result = o.a & o.b;
      ALU_OR:  r.result = o.a | o.b;
      ALU_XOR: r.result = o.a ^ o.b;
      ALU_SLT: r.result = ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0;
      ALU_SLL: r.result = o.a << o.b[4:0];
      default: r.result = o.a >> o.b[4:0];
    endcase
    r.zero = (r.result == 32'd0);
    return r;
  endfunction

  task automatic push(input int i, input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.a = a; o.b = b; o.op = op;
    opq[i][n].push_back(o);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  function automatic bit idle();
    for (int i = 0; i < 2; i++) begin
      if (outst[i].size() != 0) return 1'b0;
      for (int n = 0; n < 2; n++) if (opq[i][n].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock of requester/consumer behaviour: retire accepted ops, present queue heads.
  task automatic step();
    @(negedge clk);
    rst = ph_rst;
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (hs[i][n]) void'(opq[i][n].pop_front());
        rs_ready[i][n] = ph_rsr[i][n];
        if (opq[i][n].size() > 0) begin
          rq_valid[i][n] = 1'b1;
          rq_a[i][n]     = opq[i][n][0].a;
          rq_b[i][n]     = opq[i][n][0].b;
          rq_op[i][n]    = opq[i][n][0].op;
        end else begin
          rq_valid[i][n] = 1'b0;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 2; n++)
        hs[i][n] = rq_valid[i][n] && rq_ready[i][n];
  endtask

  // Model: one outstanding response at most; a free slot accepts the arbitration winner.
  task automatic model_step(input int i);
    int   own;
    int   win;
    bit   free;
    op_t  o;
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        check($sformatf("rst_ready i%0d r%0d", i, n), 32'(rq_ready[i][n]), 32'd0);
        check($sformatf("rst_resp_valid i%0d r%0d", i, n), 32'(rs_valid[i][n]), 32'd0);
        exp_q[i][n].delete();
      end
      outst[i].delete();
      last[i] = 1'b1;
    end else begin
      own = (outst[i].size() > 0) ? outst[i][0] : -1;
      for (int n = 0; n < 2; n++)
        check($sformatf("resp_valid i%0d r%0d", i, n), 32'(rs_valid[i][n]), 32'(own == n));
      free = (own < 0) || rs_ready[i][own];
      win = -1;
      if (free) begin
        if (rq_valid[i][0] && rq_valid[i][1]) win = (i == 1) ? 0 : (last[i] ? 0 : 1);
        else if (rq_valid[i][0]) win = 0;
        else if (rq_valid[i][1]) win = 1;
      end
      for (int n = 0; n < 2; n++)
        check($sformatf("req_ready i%0d r%0d", i, n), 32'(rq_ready[i][n]), 32'(win == n));
      if (own >= 0 && rs_ready[i][own]) void'(outst[i].pop_front());
      if (win >= 0) begin
        o.a = rq_a[i][win]; o.b = rq_b[i][win]; o.op = rq_op[i][win];
        exp_q[i][win].push_back(alu_ref(o));
        outst[i].push_back(win);
        last[i] = (win == 1);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Monitor: every presented response must match the oldest expected one for its owner.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          for (int n = 0; n < 2; n++) begin
            if (rs_valid[i][n]) begin
              if (exp_q[i][n].size() == 0) begin
                check($sformatf("unexpected_resp i%0d r%0d", i, n), 32'd1, 32'd0);
              end else begin
                check($sformatf("result i%0d r%0d", i, n), rs_result[i][n], exp_q[i][n][0].result);
                check($sformatf("zero i%0d r%0d", i, n), 32'(rs_zero[i][n]), 32'(exp_q[i][n][0].zero));
                if (rs_ready[i][n]) void'(exp_q[i][n].pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int pending;
    for (int i = 0; i < 2; i++) begin
      last[i] = 1'b1;
      for (int n = 0; n < 2; n++) begin
        rq_valid[i][n] = 1'b0;
        rq_a[i][n]     = '0;
        rq_b[i][n]     = '0;
        rq_op[i][n]    = '0;
        rs_ready[i][n] = 1'b1;
        ph_rsr[i][n]   = 1'b1;
        hs[i][n]       = 1'b0;
      end
    end
    ph_rst = 1'b1;
    repeat (2) step();
    ph_rst = 1'b0;

    push(0, 0, ALU_ADD, 32'd5, 32'd7);
    repeat (3) step();

    push(0, 0, ALU_SUB, 32'd9, 32'd9);
    push(0, 1, ALU_OR, 32'hF0, 32'h0F);
    push(0, 0, ALU_ADD, 32'd1, 32'd2);
    push(0, 1, ALU_ADD, 32'd3, 32'd4);
    repeat (6) step();

    ph_rsr[0][1] = 1'b0;
    push(0, 1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    step();
    push(0, 0, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    repeat (3) step();
    ph_rsr[0][1] = 1'b1;
    repeat (3) step();

    push(0, 0, ALU_SLL, 32'd1, 32'd31);
    push(0, 0, ALU_SRL, 32'h8000_0000, 32'd31);
    push(0, 0, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    repeat (5) step();

    push(0, 1, ALU_XOR, 32'h1234_5678, 32'hFFFF_0000);
    step();
    ph_rst = 1'b1;
    step();
    ph_rst = 1'b0;
    push(0, 0, ALU_ADD, 32'd10, 32'd20);
    push(0, 1, ALU_SUB, 32'd3, 32'd5);
    repeat (4) step();

    for (int k = 0; k < 4; k++) begin
      push(1, 0, ALU_ADD, 32'(k), 32'd100);
      push(1, 1, ALU_XOR, 32'(k), 32'hFF);
    end
    repeat (12) step();

    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        for (int n = 0; n < 2; n++) begin
          if (opq[i][n].size() < 2 && $urandom_range(0, 2) == 0)
            push(i, n, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
          ph_rsr[i][n] = ($urandom_range(0, 3) != 0);
        end
      end
      ph_rst = ($urandom_range(0, 199) == 0);
      step();
    end

    ph_rst = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 2; n++)
        ph_rsr[i][n] = 1'b1;
    for (int k = 0; k < 200 && !idle(); k++) step();
    repeat (3) step();
    check("drain_idle", 32'(idle()), 32'd1);
    pending = 0;
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 2; n++)
        pending += exp_q[i][n].size();
    check("responses_delivered", 32'(pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
